// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sliced magnitude comparator.
// A compare result is a {gt, lt} pair; equality is implied when both are 0.
// merge_result combines a more significant slice with a less significant one.
package cmp_pkg;

    localparam int SLICE_W = 2;

    typedef struct packed {
        logic gt;
        logic lt;
    } cmp_result_t;

    // A more significant slice that already differs decides the result;
    // only when it is equal does the less significant slice get a say.
    function automatic cmp_result_t merge_result(cmp_result_t hi, cmp_result_t lo);
        if (hi.gt || hi.lt) begin
            return hi;
        end
        return lo;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purpose: unsigned compare of one 2-bit operand slice.
// Latency: combinational.
// Backpressure: none.
module cmp2_slice
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    output logic               gt,
    output logic               lt
);

    assign gt = (a_s > b_s);
    assign lt = (a_s < b_s);

endmodule

// File: rtl/cmp4_registered.sv
// Purpose: registered unsigned greater/less/equal compare of two WIDTH-bit operands.
// Latency: 1 cycle from in_valid sample to out_valid.
// Backpressure: none; accepts a new pair every cycle, flags hold while in_valid is low.
module cmp4_registered
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             greater,
    output logic             less,
    output logic             equal
);

    localparam int NSLICE = WIDTH / SLICE_W;

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $fatal(1, "cmp4_registered: WIDTH must be even and at least 2");
    end

    // Per-slice compare results.
    logic [NSLICE-1:0] w_slice_gt;
    logic [NSLICE-1:0] w_slice_lt;

    // Merge chain, index NSLICE is the empty (equal) seed above the MSB slice;
    // index 0 is the fully merged result.
    logic [NSLICE:0]   w_chain_gt;
    logic [NSLICE:0]   w_chain_lt;

    logic              w_gt_all;
    logic              w_lt_all;
    logic              w_eq_all;

    assign w_chain_gt[NSLICE] = 1'b0;
    assign w_chain_lt[NSLICE] = 1'b0;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        cmp2_slice u_slice (
            .a_s (a[i*SLICE_W +: SLICE_W]),
            .b_s (b[i*SLICE_W +: SLICE_W]),
            .gt  (w_slice_gt[i]),
            .lt  (w_slice_lt[i])
        );

        assign {w_chain_gt[i], w_chain_lt[i]} = merge_result(
            cmp_result_t'{gt: w_chain_gt[i+1], lt: w_chain_lt[i+1]},
            cmp_result_t'{gt: w_slice_gt[i],   lt: w_slice_lt[i]});
    end

    assign w_gt_all = w_chain_gt[0];
    assign w_lt_all = w_chain_lt[0];
    assign w_eq_all = ~w_gt_all & ~w_lt_all;

    logic r_out_valid;
    logic r_greater;
    logic r_less;
    logic r_equal;

    // Capture the merged result on a valid sample; otherwise hold the flags
    // (so X on idle operands never reaches them) and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_greater   <= 1'b0;
            r_less      <= 1'b0;
            r_equal     <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_greater <= w_gt_all;
                r_less    <= w_lt_all;
                r_equal   <= w_eq_all;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign greater   = r_greater;
    assign less      = r_less;
    assign equal     = r_equal;

endmodule

// File: tb/tb_cmp4_registered.sv
// Bench for cmp4_registered at WIDTH=4 and WIDTH=8, driven in parallel.
// Expected flags come from plain integer comparison of the sampled operands.
module tb_cmp4_registered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld4, vld8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;

    logic ov4, g4, l4, q4;
    logic ov8, g8, l8, q8;

    // Reference model state.
    logic e4_v, e4_g, e4_l, e4_q;
    logic e8_v, e8_g, e8_l, e8_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp4_registered #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld4), .a(a4), .b(b4),
        .out_valid(ov4), .greater(g4), .less(l4), .equal(q4)
    );

    cmp4_registered #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld8), .a(a8), .b(b8),
        .out_valid(ov8), .greater(g8), .less(l8), .equal(q8)
    );

    task automatic model_reset();
        {e4_v, e4_g, e4_l, e4_q} = 4'b0;
        {e8_v, e8_g, e8_l, e8_q} = 4'b0;
    endtask

    // Advance one rising edge, update the model with what the DUT sampled,
    // and leave the caller 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            e4_v = vld4;
            if (vld4) begin
                e4_g = (int'(a4) > int'(b4));
                e4_l = (int'(a4) < int'(b4));
                e4_q = (int'(a4) == int'(b4));
            end
            e8_v = vld8;
            if (vld8) begin
                e8_g = (int'(a8) > int'(b8));
                e8_l = (int'(a8) < int'(b8));
                e8_q = (int'(a8) == int'(b8));
            end
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".v4"}, ov4, e4_v);
        chk({tag, ".g4"}, g4,  e4_g);
        chk({tag, ".l4"}, l4,  e4_l);
        chk({tag, ".e4"}, q4,  e4_q);
        chk({tag, ".v8"}, ov8, e8_v);
        chk({tag, ".g8"}, g8,  e8_g);
        chk({tag, ".l8"}, l8,  e8_l);
        chk({tag, ".e8"}, q8,  e8_q);
        if (ov4) begin
            checks++;
            assert ($countones({g4, l4, q4}) == 1) else begin
                failures++;
                $error("FAIL %s onehot4 got=%b%b%b exp=one-hot", tag, g4, l4, q4);
            end
        end
        if (ov8) begin
            checks++;
            assert ($countones({g8, l8, q8}) == 1) else begin
                failures++;
                $error("FAIL %s onehot8 got=%b%b%b exp=one-hot", tag, g8, l8, q8);
            end
        end
    endtask

    task automatic rand8();
        a8 = 8'($urandom);
        b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b1;
        vld4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
        vld8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("rst_hold");
        end

        // Release and take the first sample.
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("rst_first");
        chk("rst_first_gt_const", g4, 1'b1);

        // Exhaustive 4-bit sweep, one pair per cycle; 8-bit side random.
        for (int p = 0; p < 256; p++) begin
            logic [7:0] pr;
            pr = 8'(p);
            {a4, b4} = pr;
            rand8();
            tick();
            check_all("sweep");
        end

        // Slice priority and boundary pairs.
        a4 = 4'b1000; b4 = 4'b0111; a8 = 8'h80; b8 = 8'h7F;
        tick(); check_all("prio_hi");
        chk("w8_80_7f_gt", g8, 1'b1);
        a4 = 4'b0110; b4 = 4'b0101; a8 = 8'hFF; b8 = 8'hFF;
        tick(); check_all("prio_lo");
        chk("w8_ff_ff_eq", q8, 1'b1);
        a4 = 4'b1001; b4 = 4'b1010; a8 = 8'h00; b8 = 8'hFF;
        tick(); check_all("prio_less");
        a4 = 4'h0; b4 = 4'h0; a8 = 8'h5A; b8 = 8'h5B;
        tick(); check_all("zero_eq");

        // Hold: sample 2 vs 9, then idle with changing and unknown operands.
        a4 = 4'h2; b4 = 4'h9; rand8();
        tick(); check_all("hold_sample");
        for (int i = 0; i < 3; i++) begin
            vld4 = 1'b0; vld8 = 1'b0;
            if (i == 1) begin
                a4 = 'x; b4 = 'x; a8 = 'x; b8 = 'x;
            end else begin
                a4 = 4'($urandom); b4 = 4'($urandom); rand8();
            end
            tick();
            check_all("hold_idle");
            chk("hold_less_const", l4, 1'b1);
        end

        // Random stream with random valids.
        for (int i = 0; i < 300; i++) begin
            vld4 = ($urandom_range(0, 3) != 0);
            vld8 = ($urandom_range(0, 3) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom); rand8();
            tick();
            check_all("rand");
        end

        // Mid-stream reset between edges.
        vld4 = 1'b1; vld8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); rand8();
            tick();
            check_all("mid_stream");
        end
        a4 = 4'h7; b4 = 4'h1; rand8();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'h7; b4 = 4'h8; a8 = 8'h10; b8 = 8'h0F;
        tick();
        check_all("mid_rst_first");
        vld4 = 1'b0; vld8 = 1'b0;
        tick();
        check_all("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp4_registered.md
Name: cmp4_registered

Overview:
- Registered unsigned magnitude comparator for two WIDTH-bit operands (default 4).
- Built as a tree of 2-bit compare slices merged MSB-first, then one output register stage.
- Sits in datapath control logic wherever a one-cycle-latency greater/less/equal decision is needed.

Parameters:
- WIDTH, 4, operand width in bits; must be even and at least 2; values outside this are rejected by an elaboration-time assertion.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a and b are sampled on this clock edge
- a  input  WIDTH  unsigned operand A
- b  input  WIDTH  unsigned operand B
- out_valid  output  1  result registers hold the comparison of the last sampled pair
- greater  output  1  registered: a > b
- less  output  1  registered: a < b
- equal  output  1  registered: a == b

Behaviour:
- Reset: the block has one clock, and reset is asynchronous and active-low. While rst_n = 0, greater, less, equal and out_valid are all 0 immediately, independent of clk. The first sample is taken on the first rising clk edge after rst_n deasserts.
- Comparison is unsigned. There is no sign interpretation or overflow.
- Combinational core:
  - Split a and b into WIDTH/2 two-bit slices.
  - Each slice produces gt = (a_s > b_s) and lt = (a_s < b_s).
  - Merge MSB-first: a higher slice with gt or lt set decides the result. Otherwise the next lower slice decides.
  - Final result: gt_all, lt_all, and eq_all = ~gt_all & ~lt_all.
- Register stage, on each rising clk edge:
  - If in_valid = 1: greater <= gt_all, less <= lt_all, equal <= eq_all, out_valid <= 1.
  - If in_valid = 0: greater, less and equal hold their values, and out_valid <= 0.
- Latency is 1 cycle. Back-to-back in_valid every cycle is supported at full throughput, with no backpressure.
- Invariant: when out_valid = 1, exactly one of greater, less, equal is 1.
- After reset, and before the first valid sample, all three result flags are 0.
- Boundaries:
  - a = b = 0 gives equal.
  - a = all ones, b = 0 gives greater.
  - a = 0, b = all ones gives less.
  - Equal upper slices with different lower slices are decided by the lower slice.
- Reset mid-stream: an asserted rst_n clears all outputs within the same cycle, and the pending sample is discarded.
- X on a or b with in_valid = 0 must not propagate into the held outputs.

Decomposition:
- A shared package cmp_pkg holds:
  - localparam SLICE_W = 2
  - a typedef cmp_result_t, a packed struct {gt, lt}
  - a function merge_result(hi, lo) implementing the MSB-priority merge.
- Sub-module cmp2_slice: a combinational 2-bit compare with inputs a_s, b_s and outputs gt, lt. The top level generates WIDTH/2 instances and a merge chain, plus the register stage.

Test Plan:
- Reset: hold rst_n = 0 while driving a = 4'hF, b = 4'h0, in_valid = 1 → all outputs 0. Release rst_n; one edge later → greater = 1, less = 0, equal = 0, out_valid = 1.
- Exhaustive sweep: drive all 256 {a,b} pairs from 8'h00 to 8'hFF, one per cycle with in_valid = 1. Each result must appear the cycle after its sample. Examples: a = 4'h3, b = 4'h3 → equal; a = 4'h4, b = 4'h3 → greater; a = 4'h7, b = 4'h8 → less. Check the one-hot invariant every valid cycle.
- Slice priority:
  - a = 4'b1000, b = 4'b0111 → greater (upper slice decides).
  - a = 4'b0110, b = 4'b0101 → greater (upper slices equal, lower slice decides).
  - a = 4'b1001, b = 4'b1010 → less.
- Hold: sample a = 4'h2, b = 4'h9, then drop in_valid for 3 cycles while changing a and b → less stays 1 and out_valid = 0 during those cycles.
- Mid-stream reset: stream pairs, assert rst_n low asynchronously between edges → outputs go to 0 before the next edge. After release, the first valid result is correct.
- Parameter: WIDTH = 8, a = 8'h80, b = 8'h7F → greater. a = 8'hFF, b = 8'hFF → equal.
